// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with redirect priority, return-address stack and sticky errors
// Optional trace output is compiled in when PC_UNIT_TRACE_EN is defined.
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      INC          = 4,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             br_taken_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             jmp_i,
  input  logic [WIDTH-1:0] jmp_target_i,
  input  logic             call_i,
  input  logic             ret_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus_o,
  output logic             ras_empty_o,
  output logic             ras_full_o,
  output logic [1:0]       err_o
);

  localparam int unsigned      PTR_W      = $clog2(RAS_DEPTH);
  localparam int unsigned      CNT_W      = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);
  localparam logic [PTR_W-1:0] PTR_MAX    = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       err_q, err_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] target;
  logic             redirect;
  logic             ras_we;
  logic [PTR_W-1:0] ras_waddr;
  logic [PTR_W-1:0] top_inc;
  logic [PTR_W-1:0] top_dec;

  assign pc_plus = pc_q + WIDTH'(INC);
  // Explicit wrap keeps the circular buffer correct for non-power-of-two depths.
  assign top_inc = (top_q == PTR_MAX) ? '0 : top_q + 1'b1;
  assign top_dec = (top_q == '0) ? PTR_MAX : top_q - 1'b1;

  always_comb begin
    pc_d      = pc_q;
    top_d     = top_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    target    = '0;
    redirect  = 1'b0;
    ras_we    = 1'b0;
    ras_waddr = top_inc;
    if (!stall_i) begin
      pc_d = pc_plus;
      if (ret_i) begin
        if (cnt_q != '0) begin
          target   = ras_q[top_q];
          redirect = 1'b1;
        end else begin
          err_d[1] = 1'b1;
        end
      end else if (jmp_i) begin
        target   = jmp_target_i;
        redirect = 1'b1;
      end else if (br_taken_i) begin
        target   = br_target_i;
        redirect = 1'b1;
      end
      if (redirect) begin
        pc_d = target & ~ALIGN_MASK;
        if ((target & ALIGN_MASK) != '0) err_d[0] = 1'b1;
      end
      // Call+ret with a live entry swaps the top in place instead of pop-then-push.
      if (call_i && ret_i && (cnt_q != '0)) begin
        ras_we    = 1'b1;
        ras_waddr = top_q;
      end else if (call_i) begin
        ras_we = 1'b1;
        top_d  = top_inc;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end else if (ret_i && (cnt_q != '0)) begin
        top_d = top_dec;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_VECTOR;
      top_q <= '0;
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ras_we) ras_q[ras_waddr] <= pc_plus;
  end

`ifdef PC_UNIT_TRACE_EN
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      $display("@%0t: PC::RESET; PC is now %0h", $time, RESET_VECTOR);
    end else if (!stall_i) begin
      $display("@%0t: PC is now %0h", $time, pc_d);
      if (call_i && !ret_i && (cnt_q == CNT_MAX))
        $display("@%0t: RAS overflow, oldest entry overwritten", $time);
      if (ret_i && (cnt_q == '0))
        $display("@%0t: RAS underflow", $time);
    end
  end
`endif

  assign pc_o        = pc_q;
  assign pc_plus_o   = pc_plus;
  assign ras_empty_o = (cnt_q == '0);
  assign ras_full_o  = (cnt_q == CNT_MAX);
  assign err_o       = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed and random checks of pc_unit against a queue-based reference model
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, br_taken = 1'b0, jmp = 1'b0, call = 1'b0, ret = 1'b0;
  logic [31:0] br_target = '0, jmp_target = '0;
  logic [31:0] pc, pc_plus;
  logic        ras_empty, ras_full;
  logic [1:0]  err;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [1:0]  m_err;
  logic [31:0] m_ras[$];

  always #5 clk = ~clk;

  pc_unit #(.WIDTH(32), .RESET_VECTOR(32'h100), .INC(4), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall),
    .br_taken_i(br_taken), .br_target_i(br_target),
    .jmp_i(jmp), .jmp_target_i(jmp_target),
    .call_i(call), .ret_i(ret),
    .pc_o(pc), .pc_plus_o(pc_plus),
    .ras_empty_o(ras_empty), .ras_full_o(ras_full), .err_o(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".pc_plus"}, pc_plus, m_pc + 32'd4);
    chk({tag, ".ras_empty"}, {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
    chk({tag, ".ras_full"}, {31'd0, ras_full}, {31'd0, m_ras.size() == 4});
    chk({tag, ".err"}, {30'd0, err}, {30'd0, m_err});
  endtask

  task automatic model_reset();
    m_pc  = 32'h100;
    m_err = 2'b00;
    m_ras.delete();
  endtask

  // One clock of architectural behaviour: pick next PC by priority, then update the stack.
  task automatic model_step(input logic s, b, input logic [31:0] bt,
                            input logic j, input logic [31:0] jt, input logic c, r);
    logic [31:0] tgt, ret_addr;
    logic        redir;
    int          n;
    if (s) return;
    ret_addr = m_pc + 32'd4;
    redir    = 1'b0;
    tgt      = '0;
    n        = m_ras.size();
    if (r && n > 0)  begin tgt = m_ras[n-1]; redir = 1'b1; end
    else if (r)      m_err[1] = 1'b1;
    else if (j)      begin tgt = jt; redir = 1'b1; end
    else if (b)      begin tgt = bt; redir = 1'b1; end
    if (redir) begin
      if (tgt % 4 != 0) m_err[0] = 1'b1;
      m_pc = tgt - (tgt % 4);
    end else begin
      m_pc = ret_addr;
    end
    if (c && r && n > 0) m_ras[n-1] = ret_addr;
    else if (c) begin
      m_ras.push_back(ret_addr);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
    end else if (r && n > 0) void'(m_ras.pop_back());
  endtask

  task automatic step(input string tag, input logic s, b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt, input logic c, r);
    stall = s; br_taken = b; br_target = bt; jmp = j; jmp_target = jt; call = c; ret = r;
    model_step(s, b, bt, j, jt, c, r);
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    chk_all("reset");
    rst = 1'b0;

    step("seq1", 0, 0, 0, 0, 0, 0, 0);
    step("seq2", 0, 0, 0, 0, 0, 0, 0);
    step("seq3", 0, 0, 0, 0, 0, 0, 0);
    chk("tp_seq_pc", pc, 32'h10C);
    chk("tp_seq_err", {30'd0, err}, 32'd0);

    step("jmp_over_br", 0, 1, 32'h200, 1, 32'h300, 0, 0);
    chk("tp_jmp_pc", pc, 32'h300);
    step("stall_hold", 1, 1, 32'h200, 1, 32'h300, 0, 0);
    chk("tp_stall_pc", pc, 32'h300);

    step("to_top", 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    step("wrap", 0, 0, 0, 0, 0, 0, 0);
    chk("tp_wrap_pc", pc, 32'h0);
    chk("tp_wrap_err", {30'd0, err}, 32'd0);

    for (int k = 1; k <= 5; k++) begin
      step("call_setup", 0, 0, 0, 1, 32'(k * 16), 0, 0);
      step("call", 0, 0, 0, 1, 32'h1000, 1, 0);
    end
    chk("tp_ras_full", {31'd0, ras_full}, 32'd1);
    step("ret1", 0, 0, 0, 0, 0, 0, 1);
    chk("tp_ret1", pc, 32'h54);
    step("ret2", 0, 0, 0, 0, 0, 0, 1);
    chk("tp_ret2", pc, 32'h44);
    step("ret3", 0, 0, 0, 0, 0, 0, 1);
    chk("tp_ret3", pc, 32'h34);
    step("ret4", 0, 0, 0, 0, 0, 0, 1);
    chk("tp_ret4", pc, 32'h24);
    step("ret_uf", 0, 0, 0, 0, 0, 0, 1);
    chk("tp_uf_pc", pc, 32'h28);
    chk("tp_uf_err", {30'd0, err}, 32'h2);

    step("call_ret_empty", 0, 0, 0, 0, 0, 1, 1);
    step("call_ret_live", 0, 0, 0, 1, 32'h700, 1, 1);

    step("misalign", 0, 0, 0, 1, 32'h203, 0, 0);
    chk("tp_mis_pc", pc, 32'h200);
    chk("tp_mis_err0", {31'd0, err[0]}, 32'd1);
    step("legal_jmp", 0, 0, 0, 1, 32'h400, 0, 0);
    chk("tp_sticky_err0", {31'd0, err[0]}, 32'd1);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] bt, jt;
      bt = $urandom;
      jt = $urandom;
      if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
      step("rand", $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, bt,
           $urandom_range(0, 5) == 0, jt, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
    end

    stall = 1'b0; br_taken = 1'b0; ret = 1'b0;
    call = 1'b1; jmp = 1'b1; jmp_target = 32'h500;
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk_all("async_rst");
    chk("tp_async_pc", pc, 32'h100);
    call = 1'b0; jmp = 1'b0;
    #2;
    rst = 1'b0;
    step("post_rst", 0, 0, 0, 0, 0, 0, 0);
    chk("tp_post_rst_pc", pc, 32'h104);
    chk("tp_post_rst_empty", {31'd0, ras_empty}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
